// File: rtl/text_fetch.sv
// Text-mode pixel fetch pipeline: maps (DrawX, DrawY) to a VRAM word, a glyph row and a pixel bit.
// Optional blinking cursor is enabled with the TEXT_FETCH_CURSOR_EN macro.
module text_fetch (
    input  logic        CLK,
    input  logic        RESET,
`ifdef TEXT_FETCH_CURSOR_EN
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
`endif
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        vram_read,
    output logic [9:0]  vram_addr,
    input  logic [31:0] vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pix_valid,
    output logic        pix_on
);

    typedef struct packed {
        logic       valid;
        logic       in_range;
        logic       cur;
        logic       inv;
        logic [1:0] k;
        logic [2:0] fx;
        logic [3:0] fy;
    } meta_t;

    meta_t       s1, s2, s3, s4;
    meta_t       s1_next;
    logic        in_range;
    logic [9:0]  word_addr;
    logic        need_read;
    logic        last_valid;
    logic [9:0]  last_addr;
    logic        cur_hit;
    logic [7:0]  char_byte;

    // Row offset is y*20 = y*16 + y*4; max 29*20 + 19 = 599 fits in 10 bits.
    assign in_range  = (DrawX < 10'd640) && (DrawY < 10'd480);
    assign word_addr = 10'({DrawY[8:4], 4'b0000}) + 10'({DrawY[8:4], 2'b00}) + 10'(DrawX[9:5]);
    assign need_read = pix_en && in_range &&
                       (!last_valid || (DrawX == 10'd0) || (word_addr != last_addr));

`ifdef TEXT_FETCH_CURSOR_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
        end else if (pix_en && (DrawX == 10'd0) && (DrawY == 10'd0)) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign cur_hit = frame_cnt[5] && in_range &&
                     (DrawX[9:3] == cursor_col) && (DrawY[8:4] == cursor_row);
`else
    assign cur_hit = 1'b0;
`endif

    always_comb begin
        s1_next          = '0;
        s1_next.valid    = pix_en;
        s1_next.in_range = in_range;
        s1_next.cur      = cur_hit;
        s1_next.k        = DrawX[4:3];
        s1_next.fx       = DrawX[2:0];
        s1_next.fy       = DrawY[3:0];
    end

    // Stage 1: address issue and word-reuse tracking.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vram_read  <= 1'b0;
            vram_addr  <= '0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            s1         <= '0;
        end else begin
            vram_read <= need_read;
            if (need_read) begin
                vram_addr <= word_addr;
            end
            if (pix_en && in_range) begin
                last_valid <= 1'b1;
                last_addr  <= word_addr;
            end
            s1 <= s1_next;
        end
    end

    // vram_data is either the word just read or the held word that this pixel reuses.
    assign char_byte = vram_data[{s2.k, 3'b000} +: 8];

    // Stages 2-4 plus the output register; the glyph ROM adds its own cycle between s3 and s4.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s2        <= '0;
            s3        <= '0;
            s4        <= '0;
            font_addr <= '0;
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
        end else begin
            s2 <= s1;
            s3 <= s2;
            s3.inv <= char_byte[7];
            if (s2.valid && s2.in_range) begin
                font_addr <= {char_byte[6:0], s2.fy};
            end
            s4        <= s3;
            pix_valid <= s4.valid;
            pix_on    <= s4.valid && s4.in_range && (font_data[~s4.fx] ^ s4.inv ^ s4.cur);
        end
    end

endmodule

// File: tb/tb_text_fetch.sv
// Bench for text_fetch: VRAM and glyph ROM models plus a pixel-level reference model.
// Define TEXT_FETCH_CURSOR_EN for both files to exercise the cursor build.
module tb_text_fetch;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        pix_en = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        vram_read;
    logic [9:0]  vram_addr;
    logic [31:0] vram_data = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        pix_valid;
    logic        pix_on;
`ifdef TEXT_FETCH_CURSOR_EN
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
`endif

    text_fetch dut (
        .CLK(CLK),
        .RESET(RESET),
`ifdef TEXT_FETCH_CURSOR_EN
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
`endif
        .pix_en(pix_en),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .vram_read(vram_read),
        .vram_addr(vram_addr),
        .vram_data(vram_data),
        .font_addr(font_addr),
        .font_data(font_data),
        .pix_valid(pix_valid),
        .pix_on(pix_on)
    );

    always #5 CLK = ~CLK;

    logic [31:0] vram [600];
    logic [7:0]  rom  [2048];

    always @(posedge CLK) begin
        if (vram_read && (vram_addr < 10'd600)) vram_data <= vram[vram_addr];
        font_data <= rom[font_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_reads = 0;

    // Expectations scheduled by cycle (ring of 64 slots).
    logic        ev  [64];
    logic        eo  [64];
    logic        efv [64];
    logic [10:0] efa [64];

    logic        m_last_v = 1'b0;
    int unsigned m_last_a = 0;
    int unsigned m_frame = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            ev[i] = 1'b0; eo[i] = 1'b0; efv[i] = 1'b0; efa[i] = '0;
        end
        m_last_v = 1'b0;
        m_frame  = 0;
    endtask

    // One clock with a pixel (or bubble) presented; checks all outputs for that cycle.
    task automatic step(input logic pe, input int unsigned x, input int unsigned y);
        logic        inr, er, curf;
        int unsigned wa, ch;
        logic [7:0]  glyph;
        pix_en = pe; DrawX = 10'(x); DrawY = 10'(y);
        @(posedge CLK); #1; cyc++;
        inr  = (x < 640) && (y < 480);
        wa   = (y / 16) * 20 + x / 32;
        er   = pe && inr && (!m_last_v || x == 0 || wa != m_last_a);
        curf = 1'b0;
`ifdef TEXT_FETCH_CURSOR_EN
        curf = (m_frame >= 32) && inr && (x / 8 == cursor_col) && (y / 16 == cursor_row);
        if (pe && x == 0 && y == 0) m_frame = (m_frame + 1) % 64;
`endif
        if (pe && inr) begin m_last_v = 1'b1; m_last_a = wa; end
        ev[(cyc + 4) % 64]  = pe;
        eo[(cyc + 4) % 64]  = 1'b0;
        efv[(cyc + 2) % 64] = pe && inr;
        if (pe && inr) begin
            ch    = (vram[wa] >> (8 * ((x / 8) % 4))) & 32'hFF;
            glyph = rom[(ch % 128) * 16 + y % 16];
            efa[(cyc + 2) % 64] = 11'((ch % 128) * 16 + y % 16);
            eo[(cyc + 4) % 64]  = glyph[7 - x % 8] ^ (ch >= 128) ^ curf;
        end
        if (vram_read) n_reads++;
        chk("vram_read", 32'(vram_read), 32'(er));
        if (er) chk("vram_addr", 32'(vram_addr), wa);
        if (efv[cyc % 64]) chk("font_addr", 32'(font_addr), 32'(efa[cyc % 64]));
        chk("pix_valid", 32'(pix_valid), 32'(ev[cyc % 64]));
        if (ev[cyc % 64]) chk("pix_on", 32'(pix_on), 32'(eo[cyc % 64]));
        ev[cyc % 64] = 1'b0; efv[cyc % 64] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vram_read"}, 32'(vram_read), 32'd0);
        chk({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
        chk({tag, "_font_addr"}, 32'(font_addr), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_on"},    32'(pix_on),    32'd0);
    endtask

    initial begin
        int reads0;
        int unsigned sx, sy;
        for (int i = 0; i < 600; i++) vram[i] = $urandom;
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        vram[0]  = 32'h0000_0041;
        vram[20] = 32'h0000_00C1;
        rom[11'h410] = 8'hFF;
        clear_model();

        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset");
        RESET = 1'b0;

        // Basic character 'A' at (0,0), then let it drain.
        step(1'b1, 0, 0);
        repeat (5) step(1'b0, 0, 0);

        // Row sweep of two words with back-to-back pixels.
        reads0 = n_reads;
        for (int x = 0; x < 64; x++) step(1'b1, x, 0);
        repeat (5) step(1'b0, 0, 0);
        chk("sweep_reads", 32'(n_reads - reads0), 32'd2);

        // Bottom-right corner, out-of-range column, inverted glyph.
        step(1'b1, 639, 479);
        step(1'b1, 700, 10);
        step(1'b1, 0, 16);
        step(1'b1, 5, 500);
        repeat (5) step(1'b0, 0, 0);

        // Randomized scan: runs of consecutive pixels mixed with jumps and bubbles.
        sx = 0; sy = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sx = $urandom_range(0, 719);
                sy = $urandom_range(0, 499);
            end else begin
                sx = (sx + 1) % 720;
            end
            step($urandom_range(0, 3) != 0, sx, sy);
        end
        repeat (5) step(1'b0, 0, 0);

        // Reset with three pixels in flight.
        step(1'b1, 8, 0);
        step(1'b1, 9, 0);
        step(1'b1, 10, 0);
        #2 RESET = 1'b1;
        #1 chk_all_zero("midreset");
        clear_model();
        pix_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 0, 0);
        step(1'b1, 11, 0);
        repeat (5) step(1'b0, 0, 0);

`ifdef TEXT_FETCH_CURSOR_EN
        // Advance the frame counter until the blink phase is on, then hit the cursor cell.
        for (int i = 0; i < 33; i++) step(1'b1, 0, 0);
        step(1'b1, 1, 0);
        step(1'b1, 8, 0);
        repeat (5) step(1'b0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_fetch.md
TEXT_FETCH -- requirements
Module: text_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK (input, 1) is the single clock and RESET (input, 1) is the asynchronous active-high reset.
REQ-002 It SHALL have these ports, listed as name / direction / width / meaning:
- pix_en / in / 1 / pixel strobe; up to one per cycle, back-to-back allowed.
- DrawX / in / 10 / pixel column.
- DrawY / in / 10 / pixel row.
- vram_read / out / 1 / VRAM read strobe.
- vram_addr / out / 10 / VRAM word address.
- vram_data / in / 32 / VRAM registered read data; valid 1 cycle after vram_read; holds its value when vram_read is low.
- font_addr / out / 11 / glyph ROM address.
- font_data / in / 8 / synchronous glyph ROM data; valid 1 cycle after font_addr.
- pix_valid / out / 1 / pixel result valid.
- pix_on / out / 1 / foreground pixel.
- cursor_col / in / 7 / cursor column; present only with the macro.
- cursor_row / in / 5 / cursor row; present only with the macro.

Function
REQ-003 Screen geometry SHALL be 640x480 pixels, arranged as 80x30 character cells of 8x16 pixels each.
REQ-004 Each VRAM word SHALL hold 4 characters, with character k (k = DrawX[4:3]) in bits [8k+7:8k]; bit 7 is the invert flag and bits [6:0] are the character code.
REQ-005 The word address SHALL be DrawY[8:4]*20 + DrawX[9:5], with range 0..599, computed without overflow in 10 bits.
REQ-006 The pipeline SHALL be fixed at 4 stages, so pix_valid is high exactly 4 cycles after the cycle in which pix_en is sampled high. Stages:
- S1: register vram_addr and vram_read.
- S2: vram_data arrives.
- S3: font_addr = {code[6:0], DrawY[3:0]}, registered.
- S4: pix_on = font_data[7-DrawX[2:0]] XOR invert, registered.
REQ-007 Pixel coordinates (DrawX[2:0], DrawY[3:0], k, invert, in-range flag) SHALL travel with each pixel through the pipeline.
REQ-008 Word reuse: vram_read SHALL be asserted only when the computed word address differs from the last address read, or the last-address register is invalid. Otherwise S2 uses the held vram_data.
REQ-009 The last-address register SHALL be invalidated on reset and whenever an accepted pixel has DrawX == 0.
REQ-010 Out of range (DrawX >= 640 or DrawY >= 480): no vram_read is issued, the last-address state is unchanged, and the pixel still emerges after 4 cycles with pix_valid = 1 and pix_on = 0.
REQ-011 When pix_en is low, that pipeline slot SHALL be a bubble: pix_valid = 0 four cycles later, and no VRAM read is issued.
REQ-012 vram_read SHALL be a single-cycle pulse per new word, and vram_addr SHALL hold its last value when vram_read is low.
REQ-013 Arithmetic: all address arithmetic SHALL be unsigned, and font_addr SHALL be exactly 11 bits with no carry out.

Reset
REQ-014 Asserting RESET SHALL immediately set to 0: vram_read, vram_addr, font_addr, pix_valid, pix_on, all pipeline valid bits, the last-address valid bit and the blink state.
REQ-015 If reset is asserted mid-stream, all in-flight pixels SHALL be discarded, and no pix_valid may appear for pixels accepted before reset deassertion.
REQ-016 The first pix_en after reset SHALL always produce a VRAM read.

Configuration
REQ-017 The macro TEXT_FETCH_CURSOR_EN SHALL select the cursor feature:
- Defined: cursor_col and cursor_row ports exist, and a 6-bit frame counter increments on each accepted pixel with DrawX == 0 and DrawY == 0. For a pixel in cell (cursor_col, cursor_row) while frame counter bit 5 = 1, pix_on SHALL be inverted after the invert-flag XOR. Latency is unchanged.
- Not defined: the cursor ports, the frame counter and the cursor logic are absent, and behaviour is exactly as REQ-006.

Verification
REQ-018 Reset, then pix_en with (0,0) and VRAM word 0 = 0x00000041 -> vram_read = 1 with vram_addr = 0; font_addr = 0x410 two cycles later; pix_valid = 1 four cycles after pix_en; pix_on = font_data bit 7.
REQ-019 pix_en held high for DrawX 0..63 on DrawY = 0 -> exactly 2 vram_read pulses (addresses 0 and 1), and 64 consecutive pix_valid.
REQ-020 DrawY = 479, DrawX = 639 -> vram_addr = 599, font_addr row = 15, pix_on = font_data bit 0.
REQ-021 DrawX = 700 -> no vram_read; pix_valid = 1 with pix_on = 0 four cycles later.
REQ-022 Character byte 0xC1 with font_data = 0xFF -> pix_on = 0 (inverted).
REQ-023 RESET asserted while 3 pixels are in flight -> all outputs 0 immediately and no pix_valid afterwards; with TEXT_FETCH_CURSOR_EN defined, cursor (0,0) and frame counter bit 5 = 1 -> pixel (0,0) pix_on inverted.
